// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares the UART TX byte path between NUM_REQ frame producers.
// Optional stall timeout is enabled by defining TX_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned FRAME_BYTES    = 18,
    parameter int unsigned LEN_BITS       = 5,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic [NUM_REQ-1:0]              req,
    input  logic [NUM_REQ*FRAME_BYTES*8-1:0] frame_in,
    input  logic [NUM_REQ*LEN_BITS-1:0]     len_in,
    output logic [NUM_REQ-1:0]              grant,
    output logic [NUM_REQ-1:0]              done,
    output logic                            busy,
    output logic [7:0]                      tx_data,
    output logic                            tx_valid,
    input  logic                            tx_ready,
    output logic                            timeout_err
);

    localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned FW = FRAME_BYTES * 8;
    localparam int unsigned CW = $clog2(FRAME_BYTES + 1);

    typedef enum logic [1:0] {StIdle, StLoad, StSend, StDone} state_e;

    state_e              state_q, state_d;
    logic [IW-1:0]       ptr_q, ptr_d;
    logic [IW-1:0]       winner_q, winner_d;
    logic [IW-1:0]       scan_idx, pick;
    logic                pick_found;
    logic [FW-1:0]       frame_q, frame_d;
    logic [CW-1:0]       left_q, left_d;
    logic [LEN_BITS-1:0] len_sel;
    logic                tmo_hit;

    assign len_sel = len_in[int'(winner_q)*LEN_BITS +: LEN_BITS];

    // Scan starts just past the last winner so it ranks last on the next round.
    always_comb begin
        pick_found = 1'b0;
        pick       = ptr_q;
        scan_idx   = ptr_q;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            scan_idx = IW'((int'(ptr_q) + i) % NUM_REQ);
            if (!pick_found && req[scan_idx]) begin
                pick_found = 1'b1;
                pick       = scan_idx;
            end
        end
    end

`ifdef TX_ARB_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] tmo_q, tmo_d;
    logic          err_q, err_d;

    always_comb begin
        tmo_d   = '0;
        err_d   = err_q;
        tmo_hit = 1'b0;
        if (state_q == StSend && !tx_ready) begin
            if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                tmo_hit = 1'b1;
                err_d   = 1'b1;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tmo_q <= '0;
            err_q <= 1'b0;
        end else begin
            tmo_q <= tmo_d;
            err_q <= err_d;
        end
    end

    assign timeout_err = err_q;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign tmo_hit        = 1'b0;
    assign timeout_err    = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        winner_d = winner_q;
        frame_d  = frame_q;
        left_d   = left_q;
        grant    = '0;
        done     = '0;
        tx_valid = 1'b0;
        tx_data  = '0;
        busy     = (state_q != StIdle);
        unique case (state_q)
            StIdle: begin
                if (pick_found) begin
                    winner_d = pick;
                    state_d  = StLoad;
                end
            end
            StLoad: begin
                grant   = NUM_REQ'(1) << winner_q;
                frame_d = frame_in[int'(winner_q)*FW +: FW];
                if (len_sel == '0) begin
                    state_d = StDone;
                end else begin
                    left_d  = (32'(len_sel) > FRAME_BYTES) ? CW'(FRAME_BYTES) : CW'(len_sel);
                    state_d = StSend;
                end
            end
            StSend: begin
                grant    = NUM_REQ'(1) << winner_q;
                tx_valid = 1'b1;
                tx_data  = frame_q[FW-1 -: 8];
                if (tx_ready) begin
                    // Frame is a shift register: the next byte always sits at the top.
                    frame_d = frame_q << 8;
                    left_d  = left_q - 1'b1;
                    if (left_q == CW'(1)) begin
                        state_d = StDone;
                    end
                end else if (tmo_hit) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                done    = NUM_REQ'(1) << winner_q;
                ptr_d   = winner_q;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            ptr_q    <= IW'(NUM_REQ - 1);
            winner_q <= '0;
            frame_q  <= '0;
            left_q   <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            winner_q <= winner_d;
            frame_q  <= frame_d;
            left_q   <= left_d;
        end
    end

endmodule
